// File: rtl/outarb_pkg.sv
// Shared types and width defaults for the output arbiter.
package outarb_pkg;

   typedef enum logic {IDLE, VALID} state_t;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/output_arbiter_rr_picker.sv
// Combinational winner select: first requester after ptr, wrapping.
// OUTARB_FIXED_PRIO_EN switches to lowest-index-wins and ignores ptr.
module rr_picker
   import outarb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [IW-1:0]      winner,
   output logic               any_req
);

   assign any_req = |req;

`ifdef OUTARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req[i]) winner = IW'(i);
   end
`else
   int idx;

   // Walk from farthest to nearest slot so the nearest hit after ptr wins.
   always_comb begin
      winner = '0;
      idx    = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[IW'(idx)]) winner = IW'(idx);
      end
   end
`endif

endmodule

// File: rtl/output_arbiter.sv
// Arbitrates NUM_REQ producers onto one registered srdy/drdy output.
// Define OUTARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module output_arbiter
   import outarb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        GlobalReset,
   input  logic [NUM_REQ-1:0]          req_srdy,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_drdy,
   input  logic                        out_drdy,
   output logic                        srdyo,
   output logic [DATA_W-1:0]           data_out,
   output logic [clog2(NUM_REQ)-1:0]   grant_id,
   output logic [CNT_W-1:0]            xfer_count
);

   localparam int IW = clog2(NUM_REQ);

   state_t        state;
   logic [IW-1:0] winner;
   logic [IW-1:0] pick_ptr;
   logic          any_req;
   logic          load;

`ifdef OUTARB_FIXED_PRIO_EN
   assign pick_ptr = '0;
`else
   logic [IW-1:0] ptr;
   assign pick_ptr = ptr;

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) ptr <= IW'(NUM_REQ - 1);
      else if (load)    ptr <= winner;
   end
`endif

   rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req     (req_srdy),
      .ptr     (pick_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   // A grant consumes a word only when the output slot is free or draining now.
   assign load  = GlobalReset && any_req && (state == IDLE || out_drdy);
   assign srdyo = (state == VALID);

   always_comb begin
      req_drdy = '0;
      if (load) req_drdy[winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state    <= IDLE;
         data_out <= '0;
         grant_id <= '0;
      end else if (load) begin
         state    <= VALID;
         data_out <= req_data[int'(winner)*DATA_W +: DATA_W];
         grant_id <= winner;
      end else if (state == VALID && out_drdy) begin
         state    <= IDLE;
      end
   end

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset)          xfer_count <= '0;
      else if (srdyo && out_drdy) xfer_count <= xfer_count + 1'b1;
   end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter (NUM_REQ=4, CNT_W=4 to exercise counter wrap).
module tb_output_arbiter;

`ifdef OUTARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         GlobalReset;
   logic [3:0]   req_srdy;
   logic [127:0] req_data;
   logic [3:0]   req_drdy;
   logic         out_drdy;
   logic         srdyo;
   logic [31:0]  data_out;
   logic [1:0]   grant_id;
   logic [3:0]   xfer_count;

   int total = 0;
   int bad   = 0;

   output_arbiter #(.NUM_REQ(4), .DATA_W(32), .CNT_W(4)) dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .req_srdy    (req_srdy),
      .req_data    (req_data),
      .req_drdy    (req_drdy),
      .out_drdy    (out_drdy),
      .srdyo       (srdyo),
      .data_out    (data_out),
      .grant_id    (grant_id),
      .xfer_count  (xfer_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g;
      GlobalReset = 1'b0;
      req_srdy    = '0;
      req_data    = '0;
      out_drdy    = 1'b0;

      #3;
      chk("rst_srdyo", srdyo, 0);
      chk("rst_data", data_out, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_drdy", req_drdy, 0);
      chk("rst_xfer", xfer_count, 0);
      @(negedge clk) GlobalReset = 1'b1;

      // single requester
      req_data[64 +: 32] = 32'h12345678;
      req_srdy = 4'b0100;
      out_drdy = 1'b1;
      #1;
      chk("single_drdy", req_drdy, 4'b0100);
      chk("single_srdyo_pre", srdyo, 0);
      step();
      chk("single_srdyo", srdyo, 1);
      chk("single_data", data_out, 32'h12345678);
      chk("single_grant", grant_id, 2);
      req_srdy = 4'b0000;
      #1;
      chk("single_drdy_off", req_drdy, 0);
      chk("single_xfer0", xfer_count, 0);
      step();
      chk("single_xfer1", xfer_count, 1);
      chk("single_idle", srdyo, 0);
      chk("single_hold", data_out, 32'h12345678);

      // backpressure
      req_data[0 +: 32] = 32'hDEADBEEF;
      req_srdy = 4'b0001;
      out_drdy = 1'b0;
      #1;
      chk("bp_idle_grant", req_drdy, 4'b0001);
      step();
      chk("bp_load", data_out, 32'hDEADBEEF);
      chk("bp_gid", grant_id, 0);
      req_srdy = 4'b1001;
      req_data[0 +: 32]  = 32'h0BAD0BAD;
      req_data[96 +: 32] = 32'h33333333;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_drdy", req_drdy, 0);
         step();
         chk("bp_data", data_out, 32'hDEADBEEF);
         chk("bp_xfer", xfer_count, 1);
         chk("bp_srdyo", srdyo, 1);
      end
      out_drdy = 1'b1;
      #1;
      chk("bp_release_drdy", req_drdy, FIXED ? 4'b0001 : 4'b1000);
      step();
      chk("bp_next_data", data_out, FIXED ? 32'h0BAD0BAD : 32'h33333333);
      chk("bp_next_gid", grant_id, FIXED ? 0 : 3);
      chk("bp_next_xfer", xfer_count, 2);

      req_srdy = 4'b0001;
      req_data[0 +: 32] = 32'hDEADBEEF;
      #1;
      chk("b2b_drdy", req_drdy, 4'b0001);
      step();
      chk("b2b_data", data_out, 32'hDEADBEEF);
      chk("b2b_xfer", xfer_count, 3);
      out_drdy = 1'b0;
      req_srdy = 4'b1111;
      step();
      chk("hold_data", data_out, 32'hDEADBEEF);
      chk("hold_drdy", req_drdy, 0);

      // mid-VALID reset, no clock edge involved
      #3 GlobalReset = 1'b0;
      #1;
      chk("mrst_srdyo", srdyo, 0);
      chk("mrst_data", data_out, 0);
      chk("mrst_xfer", xfer_count, 0);
      chk("mrst_grant", grant_id, 0);
      chk("mrst_drdy", req_drdy, 0);
      step();
      chk("mrst_drdy_clk", req_drdy, 0);
      chk("mrst_srdyo_clk", srdyo, 0);

      // round-robin with sustained requests
      @(negedge clk);
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA0 + i;
      req_srdy = FIXED ? 4'b1011 : 4'b1111;
      out_drdy = 1'b1;
      GlobalReset = 1'b1;
      #1;
      chk("rr_first_drdy", req_drdy, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         step();
         g = FIXED ? 0 : k % 4;
         chk("rr_grant", grant_id, g);
         chk("rr_data", data_out, 32'hA0 + g);
         chk("rr_srdyo", srdyo, 1);
         chk("rr_drdy", req_drdy, FIXED ? 4'b0001 : (4'b0001 << ((k + 1) % 4)));
         chk("rr_xfer", xfer_count, k);
      end
      req_srdy = 4'b0000;
      step();
      chk("rr_drain_srdyo", srdyo, 0);
      chk("rr_drain_xfer", xfer_count, 5);

      // counter wrap: 17 transfers on a 4-bit counter
      #2 GlobalReset = 1'b0;
      #1;
      chk("wrap_rst", xfer_count, 0);
      @(negedge clk);
      GlobalReset = 1'b1;
      req_srdy = 4'b0010;
      out_drdy = 1'b1;
      for (int k = 0; k < 17; k++) begin
         step();
         chk("wrap_grant", grant_id, 1);
      end
      chk("wrap_pre", xfer_count, 0);
      req_srdy = 4'b0000;
      step();
      chk("wrap_xfer", xfer_count, 1);
      chk("wrap_srdyo", srdyo, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit output register among NUM_REQ result producers.
- Each producer offers a word with a srdy/drdy handshake. The arbiter picks one, captures its word into an internal output register, and presents it downstream with srdyo held until out_drdy accepts it.
- Sits between the datapath result stages and the top-level output port.
- Replaces ad-hoc srdyo-edge capture with a single clocked, arbitrated path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, word width.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- GlobalReset  input  1  asynchronous, active-low reset.
- req_srdy  input  NUM_REQ  bit i high means requester i has a valid word.
- req_data  input  NUM_REQ*DATA_W  word i occupies bits [i*DATA_W +: DATA_W].
- req_drdy  output  NUM_REQ  one-hot, one-cycle pulse: requester i's word is consumed this cycle.
- out_drdy  input  1  downstream accepts data_out this cycle.
- srdyo  output  1  data_out is valid.
- data_out  output  DATA_W  registered output word.
- grant_id  output  clog2(NUM_REQ)  index of the requester whose word is in data_out.
- xfer_count  output  CNT_W  number of completed downstream transfers.

Behaviour:
- Reset (GlobalReset=0, asynchronous):
  - state=IDLE, srdyo=0, data_out=0, grant_id=0, req_drdy=0, xfer_count=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
- States are IDLE and VALID.
- Winner selection: the first i with req_srdy[i]=1, searching from ptr+1 upward and wrapping modulo NUM_REQ. This is combinational from req_srdy and ptr.
- IDLE:
  - If any req_srdy is high, then at the clock edge: data_out <= word of winner, grant_id <= winner, ptr <= winner, srdyo <= 1, state -> VALID.
  - req_drdy[winner]=1 in that same cycle, driven combinationally, exactly one bit.
  - Otherwise remain in IDLE with all req_drdy=0.
- VALID:
  - srdyo=1; data_out and grant_id stay stable until out_drdy=1 at a clock edge.
  - out_drdy=1 and another request pending: back-to-back grant. Load the new winner exactly as in IDLE, pulse its req_drdy, stay in VALID. Sustained throughput is one word per cycle.
  - out_drdy=1 and no request pending: srdyo <= 0, state -> IDLE. data_out keeps its last value.
  - out_drdy=0: no req_drdy is asserted, whatever req_srdy shows.
- xfer_count increments on every edge where srdyo=1 and out_drdy=1. It wraps from 2^CNT_W-1 to 0 with no flag.
- Latency: a request seen in IDLE appears on data_out/srdyo one cycle later.
- Fairness: a continuously requesting producer waits at most NUM_REQ-1 grants.
- Simultaneous requests: resolved only by the RR pointer; no requester is starved.
- Requester obligations: a requester drops srdy or presents its next word after seeing its drdy. Changing req_data while srdy is high and drdy is low is legal; the word captured is the one present in the grant cycle.
- Mid-operation reset: all state clears immediately. A word held in VALID is discarded and not counted. No req_drdy is emitted while GlobalReset=0.
- Out-of-range grant_id values are never produced.

Optional Feature:
- Macro: OUTARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins, and the pointer is ignored. The pointer register is removed; all other behaviour is unchanged.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package outarb_pkg holds:
  - state enum (IDLE, VALID);
  - default width constants DATA_W_DEF=32, CNT_W_DEF=16;
  - a function returning clog2.
- One sub-module is natural: rr_picker.
  - Inputs: req vector and ptr.
  - Outputs: winner index and any_req.
  - Purely combinational rotate / priority-encode / unrotate; the fixed-priority variant lives inside it under the macro.

Test Plan:
- Reset: assert GlobalReset=0 mid-VALID with data_out=0xDEADBEEF -> srdyo=0, data_out=0, xfer_count=0 immediately with no clock. First request after release goes to requester 0 when all four request.
- Single requester: req_srdy=4'b0100, data 0x12345678, out_drdy=1 -> req_drdy=4'b0100 for one cycle; next cycle srdyo=1, data_out=0x12345678, grant_id=2; xfer_count=1 one cycle later.
- Round-robin: all four request continuously, out_drdy=1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles; srdyo stays high; req_drdy one-hot every cycle.
- Backpressure: out_drdy=0 for 5 cycles while VALID with requests pending -> data_out stable, req_drdy=0 throughout, xfer_count unchanged; on out_drdy=1 the next winner loads on the following edge.
- Counter wrap: CNT_W=4, 17 transfers -> xfer_count reads 1.
- OUTARB_FIXED_PRIO_EN defined, req_srdy=4'b1011 held, out_drdy=1 -> grant_id=0 every cycle; requesters 1 and 3 never granted while 0 requests.
